// File: rtl/seq_arith_unit.sv
// ---------------------------------------------------------------------------
// seq_arith_unit
//
// Multi-cycle unsigned arithmetic unit with valid/ready handshakes on both
// sides. Add and subtract complete in one cycle; multiply (shift-add) and
// divide (restoring) iterate one bit per clock for WIDTH clocks. Only one
// operation is in flight at a time.
//
// Parameters:
//   WIDTH        operand width in bits (>= 2); result is 2*WIDTH bits
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   in_valid     operands/opcode valid
//   in_ready     unit can accept a new operation (high only in IDLE)
//   a, b         WIDTH-bit unsigned operands
//   sel          opcode: 00 add, 01 sub, 10 mul, 11 div
//   out_valid    result valid (high only in DONE)
//   out_ready    consumer accepts the result
//   result       2*WIDTH-bit result; for div {remainder, quotient}
//   div_by_zero  set alongside result for a divide with b == 0
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for an operation, in_ready = 1
// CALC  | iterating a multiply or divide, one bit per clock
// DONE  | result presented, out_valid = 1, held until out_ready
// ---------------------------------------------------------------------------
module seq_arith_unit #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [1:0]         sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state, state_nxt;

  // Iteration registers. For mul: opa_r is the shifting multiplicand,
  // opb_r the shifting multiplier, acc_r the partial product. For div:
  // opa_r[WIDTH-1:0] holds the dividend shifting out / quotient shifting in,
  // opb_r the divisor, acc_r[WIDTH-1:0] the partial remainder.
  logic [1:0]       op_r;
  logic [RW-1:0]    opa_r;
  logic [RW-1:0]    acc_r;
  logic [WIDTH-1:0] opb_r;
  logic [CW-1:0]    count;

  logic accept;
  logic last_step;
  logic single_cycle_op;

  logic [RW-1:0]    a_ext;
  logic [RW-1:0]    b_ext;

  logic [RW-1:0]    mul_acc;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_quot;

  logic [RW-1:0]    step_acc;
  logic [RW-1:0]    step_opa;
  logic [WIDTH-1:0] step_opb;
  logic [RW-1:0]    final_result;

  assign a_ext = {{WIDTH{1'b0}}, a};
  assign b_ext = {{WIDTH{1'b0}}, b};

  assign accept    = in_valid && (state == IDLE);
  assign last_step = (state == CALC) && (count == LAST_STEP);

  // Divide by zero short-circuits the iteration and finishes like add/sub.
  assign single_cycle_op = (sel == OP_ADD) || (sel == OP_SUB) ||
                           ((sel == OP_DIV) && (b == '0));

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = single_cycle_op ? DONE : CALC;
        end
      end
      CALC: begin
        if (count == LAST_STEP) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // One iteration step
  // -------------------------------------------------------------------------
  always_comb begin
    mul_acc = opb_r[0] ? (acc_r + opa_r) : acc_r;

    // Shift the next dividend bit into the partial remainder and try the
    // subtraction. Because the partial remainder is always below the divisor,
    // a non-negative trial difference fits in WIDTH bits, so the top bit of
    // the (WIDTH+1)-bit difference is exactly the borrow.
    div_trial = {acc_r[WIDTH-1:0], opa_r[WIDTH-1]};
    div_diff  = div_trial - {1'b0, opb_r};
    div_ge    = ~div_diff[WIDTH];
    div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
    div_quot  = {opa_r[WIDTH-2:0], div_ge};

    if (op_r == OP_DIV) begin
      step_acc     = {{WIDTH{1'b0}}, div_rem};
      step_opa     = {{WIDTH{1'b0}}, div_quot};
      step_opb     = opb_r;
      final_result = {div_rem, div_quot};
    end else begin
      step_acc     = mul_acc;
      step_opa     = opa_r << 1;
      step_opb     = opb_r >> 1;
      final_result = mul_acc;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r        <= OP_ADD;
      opa_r       <= '0;
      opb_r       <= '0;
      acc_r       <= '0;
      count       <= '0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      op_r  <= sel;
      count <= '0;
      case (sel)
        OP_ADD: begin
          result      <= a_ext + b_ext;
          div_by_zero <= 1'b0;
        end
        OP_SUB: begin
          result      <= a_ext - b_ext;
          div_by_zero <= 1'b0;
        end
        OP_MUL: begin
          opa_r <= a_ext;
          opb_r <= b;
          acc_r <= '0;
        end
        default: begin
          if (b == '0) begin
            result      <= '0;
            div_by_zero <= 1'b1;
          end else begin
            opa_r <= a_ext;
            opb_r <= b;
            acc_r <= '0;
          end
        end
      endcase
    end else if (state == CALC) begin
      acc_r <= step_acc;
      opa_r <= step_opa;
      opb_r <= step_opb;
      count <= count + 1'b1;
      if (last_step) begin
        result      <= final_result;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: doc/seq_arith_unit.md
Name: seq_arith_unit

Overview:
- Parametrised, multi-cycle successor to the team's 3-bit combinational arithmetic unit.
- Performs add, subtract, multiply and divide on WIDTH-bit unsigned operands.
- Uses valid/ready handshakes on both input and output.
- Multiply uses an iterative shift-add datapath; divide uses an iterative restoring divider, each taking WIDTH cycles, so area stays small for wide operands. Divide also returns the remainder and flags divide-by-zero.

Parameters:
WIDTH, 8, operand width in bits (must be >= 2); result width is 2*WIDTH

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  operands/opcode valid
in_ready  output  1  unit can accept a new operation
a  input  WIDTH  operand A, unsigned
b  input  WIDTH  operand B, unsigned
sel  input  2  opcode: 00 add, 01 sub, 10 mul, 11 div
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  2*WIDTH  operation result
div_by_zero  output  1  set with result when sel=11 and b=0

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, div_by_zero=0; internal counter and operand registers cleared.
- Reset asserted mid-operation aborts the operation immediately. No result is ever presented for an aborted operation.
- States:
  - IDLE: in_ready=1.
  - CALC: iterating, in_ready=0, out_valid=0.
  - DONE: out_valid=1, in_ready=0.
- Accept: in_valid && in_ready at a rising edge. a, b and sel are captured at that edge; inputs are don't-care afterwards.
- Single-cycle ops (add, sub, div with b=0):
  - result is registered at the accept edge and the state goes to DONE.
  - out_valid is high in the cycle after accept.
- Add: result = zero-extended a + zero-extended b, full 2*WIDTH width, no overflow possible.
- Sub: result = (a - b) mod 2^(2*WIDTH); a borrow wraps, e.g. 5-7 yields all-ones-minus-one.
- Mul: result = a*b, exact.
  - Accept goes to CALC with count=0. Each CALC edge performs one shift-add step and increments count.
  - After step WIDTH (count reaches WIDTH-1 and completes), the state goes to DONE. out_valid rises WIDTH cycles after the accept edge.
- Div, b!=0: result[WIDTH-1:0]=a/b quotient, result[2*WIDTH-1:WIDTH]=a%b remainder. Restoring algorithm, one quotient bit per CALC edge, same WIDTH-cycle latency as mul.
- Div, b=0: single-cycle; result=0, div_by_zero=1.
- div_by_zero is 0 for every other operation and is updated whenever result is updated.
- DONE:
  - result and div_by_zero are held stable while out_valid && !out_ready (backpressure, no limit).
  - out_valid && out_ready at an edge transitions to IDLE and drops out_valid.
  - in_ready rises the same cycle, so the next accept is no earlier than the following edge. Maximum throughput is one add/sub per 2 cycles.
- result keeps its last value in IDLE/CALC; it is only meaningful while out_valid=1.
- in_valid in CALC/DONE is ignored; the upstream must hold it until in_ready.
- Handshake rules:
  - out_valid must never drop without out_ready.
  - Single operation in flight; no pipelining.

Test Plan:
- Reset/add: assert rst asynchronously (no clk edge) -> out_valid=0, in_ready=1, result=0. Release, then add a=200, b=100 -> one cycle later out_valid=1, result=16'h012C, div_by_zero=0.
- Sub wrap: a=5, b=7, sel=01 -> result=16'hFFFE.
- Mul latency: a=255, b=255, sel=10 -> in_ready=0 for the calculation; out_valid first high exactly 8 cycles after the accept edge; result=16'hFE01. Also a=0, b=37 -> result=0, same latency.
- Div and zero: a=200, b=7 -> after 8 cycles result=16'h041C (remainder 4, quotient 28), div_by_zero=0. Then a=9, b=0 -> one cycle later result=0, div_by_zero=1.
- Backpressure: hold out_ready=0 for 10 cycles after a mul completes -> out_valid and result stable and in_ready=0 throughout. Raise out_ready -> next cycle out_valid=0, in_ready=1. An in_valid presented during the stall is not accepted.
- Reset mid-operation: assert rst 3 cycles into a div -> outputs return to reset values asynchronously. After release, no stale out_valid appears, and a fresh add of 1+1 returns 2.
